// File: rtl/fejkon_pcie_np_tracker.sv
// rtl/fejkon_pcie_np_tracker.sv - BAR0 request tracker: in-order completions over out-of-order memory reads
// Optional statistics counters are enabled by defining FEJKON_NP_TRACKER_STATS_EN.
module fejkon_pcie_np_tracker #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int NUM_SLOTS = 32,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [7:0]        req_tag,
  input  logic [9:0]        req_len,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [SLOT_W-1:0] mem_slot,
  input  logic              rsp_valid,
  input  logic [SLOT_W-1:0] rsp_slot,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              cpl_valid,
  input  logic              cpl_ready,
  output logic [7:0]        cpl_tag,
  output logic [DATA_W-1:0] cpl_data,
  output logic              cpl_ur,
  output logic              err_ur_p,
  output logic              err_ur_np,
  output logic [SLOT_W:0]   outstanding
`ifdef FEJKON_NP_TRACKER_STATS_EN
  ,
  output logic [15:0]       stat_hwm,
  output logic [15:0]       stat_ur,
  output logic [15:0]       stat_spurious
`endif
);

  logic [NUM_SLOTS-1:0] slot_busy;
  logic [NUM_SLOTS-1:0] slot_done;
  logic [NUM_SLOTS-1:0] slot_ur;
  logic [7:0]           slot_tag  [NUM_SLOTS];
  logic [DATA_W-1:0]    slot_data [NUM_SLOTS];
  logic [SLOT_W-1:0]    wr_ptr;
  logic [SLOT_W-1:0]    rd_ptr;

  logic              full;
  logic              req_is_ur;
  logic              accept;
  logic              alloc;
  logic              issue;
  logic              rsp_hit;
  logic              head_hit;
  logic              head_done;
  logic              pop;
  logic [DATA_W-1:0] head_data;

  assign full      = (outstanding == (SLOT_W+1)'(NUM_SLOTS));
  // Writes obey the same gate so memory sees requests in arrival order
  assign req_ready = !full && (!mem_valid || mem_ready);
  assign req_is_ur = (req_addr[1:0] != 2'b00) || (req_len != 10'd1);
  assign accept    = req_valid && req_ready;
  assign alloc     = accept && !req_write;
  assign issue     = accept && !req_is_ur;
  // Responses to free or already-completed slots are dropped here
  assign rsp_hit   = rsp_valid && slot_busy[rsp_slot] && !slot_done[rsp_slot];
  // A response for the head slot bypasses the table to reach cpl_* one cycle later
  assign head_hit  = rsp_hit && (rsp_slot == rd_ptr);
  assign head_done = slot_busy[rd_ptr] && (slot_done[rd_ptr] || head_hit);
  assign head_data = head_hit ? rsp_data : slot_data[rd_ptr];
  assign pop       = head_done && (!cpl_valid || cpl_ready);

  // Slot flags, ring pointers and occupancy; retire clears after allocate/response updates
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_busy   <= '0;
      slot_done   <= '0;
      slot_ur     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (alloc) begin
        slot_busy[wr_ptr] <= 1'b1;
        slot_done[wr_ptr] <= req_is_ur;
        slot_ur[wr_ptr]   <= req_is_ur;
        wr_ptr            <= wr_ptr + SLOT_W'(1);
      end
      if (rsp_hit) begin
        slot_done[rsp_slot] <= 1'b1;
      end
      if (pop) begin
        slot_busy[rd_ptr] <= 1'b0;
        slot_done[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + SLOT_W'(1);
      end
      if (alloc && !pop) begin
        outstanding <= outstanding + (SLOT_W+1)'(1);
      end else if (!alloc && pop) begin
        outstanding <= outstanding - (SLOT_W+1)'(1);
      end
    end
  end

  // Slot payload; only meaningful while the busy flag is set, so no reset needed
  always_ff @(posedge clk) begin
    if (alloc) begin
      slot_tag[wr_ptr]  <= req_tag;
      slot_data[wr_ptr] <= '0;
    end
    if (rsp_hit) begin
      slot_data[rsp_slot] <= rsp_data;
    end
  end

  // Memory command register, held until the memory accepts it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_valid <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_slot  <= '0;
    end else if (issue) begin
      mem_valid <= 1'b1;
      mem_write <= req_write;
      mem_addr  <= req_addr;
      mem_wdata <= req_write ? req_data : '0;
      mem_slot  <= wr_ptr;
    end else if (mem_ready) begin
      mem_valid <= 1'b0;
    end
  end

  // One-cycle UR pulses, split by posted/non-posted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_ur_p  <= 1'b0;
      err_ur_np <= 1'b0;
    end else begin
      err_ur_p  <= accept && req_write && req_is_ur;
      err_ur_np <= accept && !req_write && req_is_ur;
    end
  end

  // Completion output register, loaded from the head slot in request order
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpl_valid <= 1'b0;
      cpl_tag   <= '0;
      cpl_data  <= '0;
      cpl_ur    <= 1'b0;
    end else if (pop) begin
      cpl_valid <= 1'b1;
      cpl_tag   <= slot_tag[rd_ptr];
      cpl_ur    <= slot_ur[rd_ptr];
      cpl_data  <= slot_ur[rd_ptr] ? '0 : head_data;
    end else if (cpl_ready) begin
      cpl_valid <= 1'b0;
    end
  end

`ifdef FEJKON_NP_TRACKER_STATS_EN
  // Saturating statistics: occupancy peak, UR events, ignored responses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_hwm      <= '0;
      stat_ur       <= '0;
      stat_spurious <= '0;
    end else begin
      if (16'(outstanding) > stat_hwm) begin
        stat_hwm <= 16'(outstanding);
      end
      if (accept && req_is_ur && (stat_ur != 16'hFFFF)) begin
        stat_ur <= stat_ur + 16'd1;
      end
      if (rsp_valid && !rsp_hit && (stat_spurious != 16'hFFFF)) begin
        stat_spurious <= stat_spurious + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fejkon_pcie_np_tracker.sv
// tb/tb_fejkon_pcie_np_tracker.sv - self-checking bench for fejkon_pcie_np_tracker
module tb_fejkon_pcie_np_tracker;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int NUM_SLOTS = 32;
  localparam int SLOT_W = 5;

  logic clk = 1'b0;
  logic reset_n;
  logic req_valid, req_ready, req_write;
  logic [7:0] req_tag;
  logic [9:0] req_len;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic mem_valid, mem_ready, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [SLOT_W-1:0] mem_slot;
  logic rsp_valid;
  logic [SLOT_W-1:0] rsp_slot;
  logic [DATA_W-1:0] rsp_data;
  logic cpl_valid, cpl_ready, cpl_ur;
  logic [7:0] cpl_tag;
  logic [DATA_W-1:0] cpl_data;
  logic err_ur_p, err_ur_np;
  logic [SLOT_W:0] outstanding;
`ifdef FEJKON_NP_TRACKER_STATS_EN
  logic [15:0] stat_hwm, stat_ur, stat_spurious;
`endif

  fejkon_pcie_np_tracker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLOTS(NUM_SLOTS)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_tag(req_tag),
    .req_len(req_len), .req_addr(req_addr), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_slot(mem_slot),
    .rsp_valid(rsp_valid), .rsp_slot(rsp_slot), .rsp_data(rsp_data),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag), .cpl_data(cpl_data),
    .cpl_ur(cpl_ur), .err_ur_p(err_ur_p), .err_ur_np(err_ur_np), .outstanding(outstanding)
`ifdef FEJKON_NP_TRACKER_STATS_EN
    , .stat_hwm(stat_hwm), .stat_ur(stat_ur), .stat_spurious(stat_spurious)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] tag; logic ur; logic [31:0] data;} exp_t;
  typedef struct {logic [SLOT_W-1:0] slot; logic [31:0] data;} pend_t;

  exp_t  exp_cpl[$];
  pend_t pend[$];
  logic [31:0] ref_mem [1024];
  logic [31:0] tb_mem [1024];
  int tests = 0, fails = 0;
  int n_acc = 0, n_mw = 0, n_mr = 0, n_cpl = 0, n_ur_p = 0, n_ur_np = 0;
  int exp_ur_p = 0, exp_ur_np = 0, exp_stat_ur = 0, exp_stat_spur = 0;
  bit rnd = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $error("FAIL timeout %s: observed no event, expected event within budget", name);
  endtask

  // Reference model and memory device: acceptance, memory handshakes, completions
  always @(negedge clk) begin
    logic ur;
    exp_t e;
    pend_t p;
    if (reset_n) begin
      if (req_valid && req_ready) begin
        n_acc++;
        ur = (req_addr[1:0] != 2'd0) || (req_len != 10'd1);
        if (ur) exp_stat_ur++;
        if (req_write) begin
          if (ur) exp_ur_p++;
          else ref_mem[req_addr[11:2]] = req_data;
        end else begin
          if (ur) exp_ur_np++;
          e.tag = req_tag;
          e.ur = ur;
          e.data = ur ? 32'd0 : ref_mem[req_addr[11:2]];
          exp_cpl.push_back(e);
        end
      end
      if (mem_valid && mem_ready) begin
        if (mem_write) begin
          n_mw++;
          tb_mem[mem_addr[11:2]] = mem_wdata;
        end else begin
          n_mr++;
          p.slot = mem_slot;
          p.data = tb_mem[mem_addr[11:2]];
          pend.push_back(p);
        end
      end
      if (cpl_valid && cpl_ready) begin
        n_cpl++;
        if (exp_cpl.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL cpl_unexpected: observed tag %0h, expected no completion", cpl_tag);
        end else begin
          e = exp_cpl.pop_front();
          chk("cpl_tag", 32'(cpl_tag), 32'(e.tag));
          chk("cpl_ur", 32'(cpl_ur), 32'(e.ur));
          chk("cpl_data", cpl_data, e.data);
        end
      end
      if (err_ur_p) n_ur_p++;
      if (err_ur_np) n_ur_np++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) begin
      mem_ready = ($urandom % 4) != 0;
      cpl_ready = ($urandom % 4) != 0;
    end
  endtask

  task automatic do_req(input bit w, input logic [7:0] tag, input logic [9:0] len,
                        input logic [11:0] addr, input logic [31:0] data);
    bit got;
    got = 0;
    req_write = w; req_tag = tag; req_len = len; req_addr = addr; req_data = data;
    req_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
      tick();
    end
    req_valid = 1'b0;
    if (!got) timeout_fail("req_accept");
  endtask

  task automatic send_rsp(input int k);
    pend_t p;
    p = pend[k];
    pend.delete(k);
    rsp_slot = p.slot;
    rsp_data = p.data;
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
  endtask

  task automatic wait_pend(input int n);
    int i;
    i = 0;
    while (pend.size() < n && i < 200) begin tick(); i++; end
    if (pend.size() < n) timeout_fail("wait_pend");
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (!(exp_cpl.size() == 0 && outstanding == 0 && !cpl_valid && !mem_valid) && i < 500) begin
      tick(); i++;
    end
    if (i >= 500) timeout_fail("wait_idle");
  endtask

  initial begin
    int a0, c0, mw0, mr0, i;
    logic [11:0] a;
    logic [9:0] l;
    exp_t e;
    for (int k = 0; k < 1024; k++) begin ref_mem[k] = 32'd0; tb_mem[k] = 32'd0; end
    reset_n = 0; req_valid = 0; req_write = 0; req_tag = 0; req_len = 0; req_addr = 0; req_data = 0;
    mem_ready = 1; rsp_valid = 0; rsp_slot = 0; rsp_data = 0; cpl_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_valid", 32'(mem_valid), 0);
    chk("rst_cpl_valid", 32'(cpl_valid), 0);
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_err", 32'({err_ur_p, err_ur_np}), 0);
    chk("rst_cpl_fields", 32'({cpl_tag, cpl_ur}) | cpl_data, 0);
    reset_n = 1;
    tick();

    // Write then read back through the memory echo
    mw0 = n_mw; mr0 = n_mr;
    do_req(1, 8'd0, 10'd1, 12'h010, 32'h1337);
    do_req(0, 8'd5, 10'd1, 12'h010, 32'h0);
    wait_pend(1);
    send_rsp(0);
    wait_idle();
    chk("echo_mem_writes", 32'(n_mw - mw0), 1);
    chk("echo_mem_reads", 32'(n_mr - mr0), 1);

    // Misaligned write and read become UR
    mw0 = n_mw; mr0 = n_mr; c0 = n_cpl;
    do_req(1, 8'd0, 10'd1, 12'd14, 32'hdead);
    do_req(0, 8'd3, 10'd1, 12'd14, 32'h0);
    wait_idle();
    repeat (2) tick();
    chk("ur_err_p", 32'(n_ur_p), 1);
    chk("ur_err_np", 32'(n_ur_np), 1);
    chk("ur_no_mem", 32'((n_mw - mw0) + (n_mr - mr0)), 0);
    chk("ur_cpl_count", 32'(n_cpl - c0), 1);

    // Fill all slots, then answer in reverse order
    c0 = n_cpl;
    for (int t = 0; t < 32; t++) do_req(0, 8'(t), 10'd1, 12'(($urandom % 16) * 4), 32'h0);
    wait_pend(32);
    chk("full_outstanding", 32'(outstanding), 32);
    req_write = 0; req_tag = 8'd32; req_len = 10'd1; req_addr = 12'h020; req_valid = 1;
    a0 = n_acc;
    repeat (3) begin
      @(negedge clk);
      chk("full_req_ready", 32'(req_ready), 0);
      tick();
    end
    for (int k = 31; k >= 1; k--) send_rsp(k);
    repeat (2) tick();
    chk("full_no_early_accept", 32'(n_acc - a0), 0);
    chk("full_no_early_cpl", 32'(n_cpl - c0), 0);
    send_rsp(0);
    i = 0;
    while (n_acc == a0 && i < 100) begin tick(); i++; end
    if (n_acc == a0) timeout_fail("accept_33rd");
    req_valid = 0;
    wait_pend(1);
    send_rsp(0);
    wait_idle();
    chk("full_cpl_count", 32'(n_cpl - c0), 33);
`ifdef FEJKON_NP_TRACKER_STATS_EN
    chk("stat_hwm", 32'(stat_hwm), 32);
`endif

    // Completion held under back-pressure
    cpl_ready = 0;
    do_req(0, 8'h44, 10'd1, 12'h010, 32'h0);
    wait_pend(1);
    send_rsp(0);
    i = 0;
    while (!cpl_valid && i < 50) begin tick(); i++; end
    if (!cpl_valid) timeout_fail("hold_cpl_valid");
    e = exp_cpl[0];
    c0 = n_cpl;
    repeat (10) begin
      @(negedge clk);
      chk("hold_valid", 32'(cpl_valid), 1);
      chk("hold_tag", 32'(cpl_tag), 32'(e.tag));
      chk("hold_data", cpl_data, e.data);
      tick();
    end
    cpl_ready = 1;
    repeat (4) tick();
    chk("hold_one_handshake", 32'(n_cpl - c0), 1);

    // Response for a free slot is ignored
    wait_idle();
    c0 = n_cpl;
    rsp_slot = 5'd7; rsp_data = 32'hbad0; rsp_valid = 1;
    exp_stat_spur++;
    tick();
    rsp_valid = 0;
    repeat (3) tick();
    chk("spur_no_cpl", 32'(n_cpl - c0), 0);
    chk("spur_cpl_valid", 32'(cpl_valid), 0);
`ifdef FEJKON_NP_TRACKER_STATS_EN
    chk("stat_spurious", 32'(stat_spurious), 32'(exp_stat_spur));
`endif

    // Reset with reads outstanding
    for (int t = 0; t < 5; t++) do_req(0, 8'(t + 100), 10'd1, 12'h010, 32'h0);
    wait_pend(5);
    chk("pre_rst_outstanding", 32'(outstanding), 5);
    reset_n = 0;
    #1;
    chk("mid_rst_outstanding", 32'(outstanding), 0);
    chk("mid_rst_cpl_valid", 32'(cpl_valid), 0);
    exp_cpl.delete();
    pend.delete();
    exp_stat_ur = 0; exp_stat_spur = 0;
    tick();
    tick();
    reset_n = 1;
    tick();
    do_req(1, 8'd0, 10'd1, 12'h040, 32'hcafe_f00d);
    do_req(0, 8'd9, 10'd1, 12'h040, 32'h0);
    wait_pend(1);
    send_rsp(0);
    wait_idle();
    chk("post_rst_empty", 32'(exp_cpl.size()), 0);

    // Randomized traffic with random back-pressure and response order
    rnd = 1;
    for (int n = 0; n < 300; n++) begin
      if (pend.size() > 0 && (($urandom % 2) == 0 || pend.size() >= 8)) begin
        send_rsp(int'($urandom % pend.size()));
      end else begin
        a = 12'(($urandom % 16) * 4);
        if ($urandom % 8 == 0) a[1:0] = 2'($urandom % 3 + 1);
        l = ($urandom % 8 == 0) ? 10'($urandom % 4) : 10'd1;
        do_req(1'($urandom % 2), 8'($urandom), l, a, $urandom);
      end
    end
    i = 0;
    while (!(exp_cpl.size() == 0 && outstanding == 0 && !mem_valid && !cpl_valid) && i < 2000) begin
      if (pend.size() > 0) send_rsp(int'($urandom % pend.size()));
      else tick();
      i++;
    end
    if (i >= 2000) timeout_fail("random_drain");
    rnd = 0;
    mem_ready = 1; cpl_ready = 1;
    repeat (3) tick();
    chk("final_exp_empty", 32'(exp_cpl.size()), 0);
    chk("final_outstanding", 32'(outstanding), 0);
    chk("final_err_p", 32'(n_ur_p), 32'(exp_ur_p));
    chk("final_err_np", 32'(n_ur_np), 32'(exp_ur_np));
`ifdef FEJKON_NP_TRACKER_STATS_EN
    chk("stat_ur", 32'(stat_ur), 32'(exp_stat_ur));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
